pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Control stage wrapped around the 50 MHz to 35 MHz PLL, clocked from the free-running reference clock.
  - Drives the PLL's `rst` input (upstream side).
  - Consumes the PLL's `locked` output (downstream side).
- Generates the core's system reset request and a ready flag.
- Re-resets the PLL on lock timeout and counts retries and lock losses for the debug core.

Parameters:
- SYNC_STAGES, 2: flops in the `locked` synchronizer (min 2).
- PLL_RST_CYCLES, 8: cycles `pll_rst` stays high after `rst` release or a relock.
- LOCK_TIMEOUT_CYCLES, 65536: cycles to wait for lock before re-resetting the PLL.
- LOCK_STABLE_CYCLES, 1024: cycles `locked` must stay high before release.
- CNT_W, 17: width of the shared cycle counter. Must hold the max of the three cycle parameters.

Ports:
- `refclk`, input, 1: 50 MHz free-running reference clock; only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `locked`, input, 1: PLL lock, asynchronous to `refclk`.
- `force_relock`, input, 1: single-cycle request to restart the PLL.
- `pll_rst`, output, 1: reset to the PLL.
- `sys_rst`, output, 1: system reset request for the core, high until lock is stable.
- `ready`, output, 1: clock is stable and the system is released.
- `state`, output, 2: current state encoding (0 PLL_RESET, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN).
- `retry_cnt`, output, 8: saturating count of lock timeouts.
- `loss_cnt`, output, 8: saturating count of lock losses while in RUN.

Behaviour:
- Reset: single clock `refclk`; reset is synchronous and active-high on `rst`.
  - On `rst`=1 at a rising edge: state=PLL_RESET, cnt=0, sync flops=0, `retry_cnt`=0, `loss_cnt`=0.
  - Outputs during reset: `pll_rst`=1, `sys_rst`=1, `ready`=0, `state`=0.
- `locked` synchronizer: SYNC_STAGES flops produce `locked_s`; latency is SYNC_STAGES edges.
- Outputs are Moore-decoded from the state register, with no extra pipeline:
  - `pll_rst` = (state==PLL_RESET)
  - `ready` = (state==RUN)
  - `sys_rst` = !`ready`
- Counters are registered directly.
- Priority at each edge: `rst` > `force_relock` > lock events.
- `force_relock`=1 in any state: next state PLL_RESET, cnt=0. Retry and loss counters unchanged.
- PLL_RESET: cnt++ each edge. When cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0. `pll_rst` is therefore high for exactly PLL_RST_CYCLES edges after the last edge sampling `rst`=1. `locked_s` is ignored in this state.
- WAIT_LOCK:
  - If `locked_s`: go to STABILIZE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1: go to PLL_RESET, cnt=0, `retry_cnt`++ (saturating at 255).
  - Else cnt++.
- STABILIZE:
  - If !`locked_s`: go to WAIT_LOCK, cnt=0, no counter increment (glitch restart).
  - Else if cnt==LOCK_STABLE_CYCLES-1: go to RUN.
  - Else cnt++.
- RUN:
  - cnt held at 0.
  - If !`locked_s`: go to WAIT_LOCK, cnt=0, `loss_cnt`++ (saturating at 255). `sys_rst` rises on that same edge.
- Release latency: `sys_rst` falls on the (SYNC_STAGES+LOCK_STABLE_CYCLES+1)th edge sampling `locked`=1 from WAIT_LOCK, counting the first sampling edge as 1.
- Counter saturation: 255 stays 255, no wrap.
- cnt never exceeds the active limit minus 1.
- `rst` mid-operation aborts any state immediately; counters clear.
- Unused state encodings: none exist (4 states in 2 bits); default branch goes to PLL_RESET.

Test Plan:
- Bench parameters for all scenarios: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8.
- Nominal bring-up: hold `rst` 3 cycles, release; raise `locked` 10 cycles after `pll_rst` falls.
  - `pll_rst` high exactly 4 edges after release.
  - `sys_rst`=0 and `ready`=1 on the 11th edge sampling `locked`=1.
  - `state` sequence 0,1,2,3; `retry_cnt`=0.
- Timeout: keep `locked`=0.
  - After 4 PLL_RESET + 32 WAIT_LOCK cycles, `pll_rst` re-asserts and `retry_cnt`=1.
  - After 300 retries, `retry_cnt`=255.
  - `sys_rst` stays 1 throughout.
- Stabilize glitch: `locked` high, drop for 3 cycles at STABILIZE cnt=5, then high.
  - `state` returns to 1 then 2; cnt restarts.
  - Release occurs 11 edges after `locked` is re-sampled high.
  - `retry_cnt` unchanged.
- Lock loss in RUN: drop `locked` in RUN.
  - `sys_rst`=1 and `ready`=0 on the 3rd edge after the drop.
  - `loss_cnt`=1, `pll_rst` stays 0.
  - Re-raise `locked` and confirm re-release with `loss_cnt` still 1.
- `force_relock` pulse in RUN, and separately in WAIT_LOCK cnt=20:
  - Next edge `state`=0, `pll_rst` high 4 cycles, `retry_cnt`/`loss_cnt` unchanged.
  - With `rst` and `force_relock` asserted together, counters clear (reset wins).
- `rst` mid-STABILIZE with `retry_cnt`=2, `loss_cnt`=1:
  - Next edge `state`=0, both counters 0, `pll_rst`=1.
  - Sync flops cleared: a held-high `locked` takes 2 edges to be seen again.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings:
// the PLL lock/reset pair, the relock request and the status/debug outputs.
interface pll_reset_sequencer_if;
  // No valid/ready handshake here: force_relock is a one-cycle request taken
  // on the next refclk edge; all outputs are level signals valid every cycle.
  logic       locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] state;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  locked, force_relock,
    output pll_rst, sys_rst, ready, state, retry_cnt, loss_cnt
  );

  modport slave (
    output locked, force_relock,
    input  pll_rst, sys_rst, ready, state, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock wait and lock stabilization before releasing the
// system reset; retries the PLL on lock timeout and counts retries/lock losses.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 17
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] L_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_ONE          = CNT_W'(1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [7:0]             r_retry_cnt;
  logic [7:0]             r_loss_cnt;
  logic                   w_locked_s;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= PLL_RESET;
      r_cnt       <= '0;
      r_sync      <= '0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.locked};
      if (bus.force_relock) begin
        r_state <= PLL_RESET;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          PLL_RESET: begin
            if (r_cnt == L_RST_LAST) begin
              r_state <= WAIT_LOCK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + L_ONE;
            end
          end
          WAIT_LOCK: begin
            if (w_locked_s) begin
              r_state <= STABILIZE;
              r_cnt   <= '0;
            end else if (r_cnt == L_TIMEOUT_LAST) begin
              r_state <= PLL_RESET;
              r_cnt   <= '0;
              if (r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 8'd1;
            end else begin
              r_cnt <= r_cnt + L_ONE;
            end
          end
          STABILIZE: begin
            // A lock glitch restarts the wait without counting as a retry.
            if (!w_locked_s) begin
              r_state <= WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == L_STABLE_LAST) begin
              r_state <= RUN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + L_ONE;
            end
          end
          RUN: begin
            r_cnt <= '0;
            if (!w_locked_s) begin
              r_state <= WAIT_LOCK;
              if (r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'd1;
            end
          end
          default: begin
            r_state <= PLL_RESET;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Outputs decode straight from the state register, no extra pipeline stage.
  assign bus.pll_rst   = (r_state == PLL_RESET);
  assign bus.ready     = (r_state == RUN);
  assign bus.sys_rst   = (r_state != RUN);
  assign bus.state     = r_state;
  assign bus.retry_cnt = r_retry_cnt;
  assign bus.loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a cycle table for bring-up, loss and
// relock, then hand-written sequences for timeout, glitch and reset corners.
module tb_pll_reset_sequencer;

  logic refclk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #10 refclk = ~refclk;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .CNT_W              (17)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       locked;
    logic       force_rl;
    logic [1:0] st;
    logic [7:0] retry;
    logic [7:0] loss;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic l, input logic f,
                     input logic [1:0] s, input logic [7:0] rc, input logic [7:0] lc);
    vec_t v;
    v.rst = r; v.locked = l; v.force_rl = f; v.st = s; v.retry = rc; v.loss = lc;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic l, input logic f);
    rst              = r;
    bus.locked       = l;
    bus.force_relock = f;
    @(posedge refclk);
    #1;
  endtask

  // Expected pll_rst/sys_rst/ready follow from the expected state.
  task automatic check(input string name, input logic [1:0] s,
                       input logic [7:0] rc, input logic [7:0] lc);
    logic [20:0] exp_v;
    logic [20:0] act_v;
    exp_v = {(s == 2'd0), (s != 2'd3), (s == 2'd3), s, rc, lc};
    act_v = {bus.pll_rst, bus.sys_rst, bus.ready, bus.state, bus.retry_cnt, bus.loss_cnt};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got pll_rst=%b sys_rst=%b ready=%b state=%0d retry=%0d loss=%0d, expected pll_rst=%b sys_rst=%b ready=%b state=%0d retry=%0d loss=%0d",
               name, act_v[20], act_v[19], act_v[18], act_v[17:16], act_v[15:8], act_v[7:0],
               exp_v[20], exp_v[19], exp_v[18], exp_v[17:16], exp_v[15:8], exp_v[7:0]);
    end
  endtask

  initial begin
    logic       saw_release;
    logic [1:0] es;

    rst              = 1'b1;
    bus.locked       = 1'b0;
    bus.force_relock = 1'b0;

    // Nominal bring-up: reset 3 cycles, 4 PLL_RESET edges, 10 unlocked wait cycles.
    add(3, 1, 0, 0, 2'd0, 8'd0, 8'd0);
    add(3, 0, 0, 0, 2'd0, 8'd0, 8'd0);
    add(10, 0, 0, 0, 2'd1, 8'd0, 8'd0);
    // locked high: seen on 3rd edge, released on the 11th.
    add(2, 0, 1, 0, 2'd1, 8'd0, 8'd0);
    add(8, 0, 1, 0, 2'd2, 8'd0, 8'd0);
    add(3, 0, 1, 0, 2'd3, 8'd0, 8'd0);
    // Lock loss in RUN: sys_rst rises on the 3rd edge after the drop.
    add(2, 0, 0, 0, 2'd3, 8'd0, 8'd0);
    add(1, 0, 0, 0, 2'd1, 8'd0, 8'd1);
    add(2, 0, 1, 0, 2'd1, 8'd0, 8'd1);
    add(8, 0, 1, 0, 2'd2, 8'd0, 8'd1);
    add(1, 0, 1, 0, 2'd3, 8'd0, 8'd1);
    // force_relock in RUN, then in WAIT_LOCK at cnt=20.
    add(1, 0, 1, 1, 2'd0, 8'd0, 8'd1);
    add(3, 0, 0, 0, 2'd0, 8'd0, 8'd1);
    add(21, 0, 0, 0, 2'd1, 8'd0, 8'd1);
    add(1, 0, 0, 1, 2'd0, 8'd0, 8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].locked, vecs[i].force_rl);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].retry, vecs[i].loss);
    end

    // Timeout: 4 PLL_RESET + 32 WAIT_LOCK edges, then PLL re-reset.
    for (int i = 0; i < 35; i++) step(0, 0, 0);
    check("timeout_before", 2'd1, 8'd0, 8'd1);
    step(0, 0, 0);
    check("timeout_retry1", 2'd0, 8'd1, 8'd1);

    saw_release = 1'b0;
    for (int i = 0; i < 299 * 36; i++) begin
      step(0, 0, 0);
      if (bus.sys_rst !== 1'b1) saw_release = 1'b1;
    end
    check("retry_saturate", 2'd0, 8'd255, 8'd1);
    checks++;
    if (saw_release !== 1'b0) begin
      errors++;
      $display("FAIL sys_rst_held: got sys_rst low during retries, expected held 1");
    end

    // Reset wins over force_relock.
    step(1, 0, 1);
    check("rst_over_force", 2'd0, 8'd0, 8'd0);

    for (int i = 0; i < 72; i++) step(0, 0, 0);
    check("retry_two", 2'd0, 8'd2, 8'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check("wait_entry", 2'd1, 8'd2, 8'd0);

    // Stabilize glitch: locked low for edges 9..11 after entering cnt=5.
    for (int k = 1; k <= 22; k++) begin
      step(0, (k < 9 || k > 11), 0);
      es = (k < 3) ? 2'd1 : (k < 11) ? 2'd2 : (k < 14) ? 2'd1 : (k < 22) ? 2'd2 : 2'd3;
      check($sformatf("glitch_k%0d", k), es, 8'd2, 8'd0);
    end

    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0);
      check($sformatf("loss_k%0d", k), (k < 3) ? 2'd3 : 2'd1, 8'd2, (k < 3) ? 8'd0 : 8'd1);
    end
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0);
      check($sformatf("relock_k%0d", k), (k < 3) ? 2'd1 : 2'd2, 8'd2, 8'd1);
    end

    // Reset mid-STABILIZE clears counters and the synchronizer.
    step(1, 1, 0);
    check("rst_mid_stab", 2'd0, 8'd0, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 0);
      check($sformatf("post_rst_k%0d", k), (k < 4) ? 2'd0 : (k == 4) ? 2'd1 : 2'd2, 8'd0, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
